// File: rtl/eth_pkt_serializer.sv
// -----------------------------------------------------------------------------
// eth_pkt_serializer
//
// Purpose:
//   Drains 32-bit words from the Ethernet packet FIFO's prefetched read port
//   and serialises them into a framed 8-bit byte stream for the transmit
//   engine. A packet is launched by a one-cycle start command that carries the
//   packet length in words. Sustained throughput is one byte per cycle: the
//   next word is popped in the same cycle the last byte of the current word
//   is accepted, so consecutive words leave without a bubble.
//
// Handshakes (both sides use the same rule):
//   A transfer happens on a rising clock edge where valid and the matching
//   ready/enable are both 1. The producer keeps valid and data stable until
//   that edge; the consumer may change ready/enable at any time.
//     FIFO side : fifo_vld (valid)  / fifo_rd_en (enable, combinational)
//     TX side   : tx_vld   (valid)  / tx_rdy     (ready)
//
// Ports:
//   clk         in   single clock
//   rst_n       in   asynchronous active-low reset
//   fifo_data   in   FIFO read data, valid when fifo_vld=1
//   fifo_vld    in   FIFO holds a word at its output
//   fifo_rd_en  out  pop request (word consumed on fifo_vld & fifo_rd_en)
//   pkt_start   in   one-cycle start command
//   pkt_len     in   packet length in words, sampled with pkt_start
//   busy        out  packet in progress
//   tx_data     out  output byte
//   tx_vld      out  tx_data valid
//   tx_rdy      in   downstream accepts the byte on tx_vld & tx_rdy
//   tx_last     out  final byte of the packet
//   pkt_done    out  one-cycle pulse after the final byte is accepted
//   pkt_sum     out  one's-complement payload sum (only with the macro below)
//
// Configuration:
//   ETH_PKT_SERIALIZER_SUM_EN - when defined, adds the pkt_sum output and a
//   one's-complement accumulator over the big-endian 16-bit halves of every
//   popped word. pkt_sum is stable from pkt_done until the next start.
// -----------------------------------------------------------------------------
module eth_pkt_serializer #(
    parameter int WORD_W    = 32,
    parameter int LEN_W     = 11,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] fifo_data,
    input  logic              fifo_vld,
    output logic              fifo_rd_en,
    input  logic              pkt_start,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic              busy,
`ifdef ETH_PKT_SERIALIZER_SUM_EN
    output logic [15:0]       pkt_sum,
`endif
    output logic [7:0]        tx_data,
    output logic              tx_vld,
    input  logic              tx_rdy,
    output logic              tx_last,
    output logic              pkt_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q;
    logic [WORD_W-1:0]  word_q;
    logic               loaded_q;
    logic [1:0]         byte_idx_q;
    logic [LEN_W-1:0]   words_left_q;
    logic               busy_q;
    logic               done_q;

    logic               accept;
    logic               need_load;
    logic               pop;
    logic               last_accept;
    logic [1:0]         sel_idx;

    // A byte leaves on tx_vld & tx_rdy; tx_vld is simply the loaded flag.
    assign accept     = loaded_q & tx_rdy;

    // Reload when empty, or when the last byte of the current word is being
    // accepted this very cycle (this is what keeps words back-to-back).
    assign need_load  = ~loaded_q | (accept & (byte_idx_q == 2'd3));
    assign fifo_rd_en = (state_q == SEND) & need_load & (words_left_q != '0);
    assign pop        = fifo_rd_en & fifo_vld;

    assign tx_vld     = loaded_q;
    assign tx_last    = loaded_q & (words_left_q == '0) & (byte_idx_q == 2'd3);
    assign last_accept = accept & tx_last;

    assign busy       = busy_q;
    assign pkt_done   = done_q;

    // Byte lane: MSB_FIRST walks the word from [31:24] down to [7:0].
    assign sel_idx    = (MSB_FIRST != 0) ? (2'd3 - byte_idx_q) : byte_idx_q;
    assign tx_data    = word_q[{sel_idx, 3'b000} +: 8];

`ifdef ETH_PKT_SERIALIZER_SUM_EN
    logic [16:0] sum_q;
    logic [16:0] sum_d;
    logic [16:0] add_hi;
    logic [15:0] fold_hi;
    logic [16:0] add_lo;

    // Two end-around-carry adds per word: high half first, then low half.
    // A folded carry can never overflow again (max 0xFFFE + 1).
    always_comb begin
        add_hi  = {1'b0, sum_q[15:0]} + {1'b0, fifo_data[31:16]};
        fold_hi = add_hi[15:0] + {15'd0, add_hi[16]};
        add_lo  = {1'b0, fold_hi} + {1'b0, fifo_data[15:0]};
        sum_d   = {1'b0, add_lo[15:0] + {15'd0, add_lo[16]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (state_q == IDLE && pkt_start && pkt_len != '0) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_d;
        end
    end

    assign pkt_sum = sum_q[15:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_q       <= '0;
            loaded_q     <= 1'b0;
            byte_idx_q   <= 2'd0;
            words_left_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Zero-length starts are dropped silently.
                    if (pkt_start && pkt_len != '0) begin
                        words_left_q <= pkt_len;
                        loaded_q     <= 1'b0;
                        byte_idx_q   <= 2'd0;
                        busy_q       <= 1'b1;
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    // pkt_start is not looked at here. A pop and the final
                    // accept never coincide: tx_last needs words_left == 0.
                    if (last_accept) begin
                        loaded_q   <= 1'b0;
                        byte_idx_q <= 2'd0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end else if (pop) begin
                        word_q       <= fifo_data;
                        loaded_q     <= 1'b1;
                        byte_idx_q   <= 2'd0;
                        words_left_q <= words_left_q - LEN_W'(1);
                    end else if (accept) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            loaded_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_pkt_serializer.sv
// -----------------------------------------------------------------------------
// tb_eth_pkt_serializer
//
// Bench for eth_pkt_serializer. A queue-based FIFO feeds the DUT; a byte-level
// model (pending-bytes count, expected byte queue built from each popped word)
// predicts busy, pkt_done, tx_vld, fifo_rd_en, tx_data and tx_last every cycle.
// Directed scenarios add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_eth_pkt_serializer;

  localparam int LEN_W     = 11;
  localparam int MSB_FIRST = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]      fifo_data = '0;
  logic             fifo_vld = 1'b0;
  logic             fifo_rd_en;
  logic             pkt_start = 1'b0;
  logic [LEN_W-1:0] pkt_len = '0;
  logic             busy;
  logic [7:0]       tx_data;
  logic             tx_vld;
  logic             tx_rdy = 1'b1;
  logic             tx_last;
  logic             pkt_done;
`ifdef ETH_PKT_SERIALIZER_SUM_EN
  logic [15:0]      pkt_sum;
`endif

  eth_pkt_serializer #(
    .WORD_W   (32),
    .LEN_W    (LEN_W),
    .MSB_FIRST(MSB_FIRST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_data (fifo_data),
    .fifo_vld  (fifo_vld),
    .fifo_rd_en(fifo_rd_en),
    .pkt_start (pkt_start),
    .pkt_len   (pkt_len),
    .busy      (busy),
`ifdef ETH_PKT_SERIALIZER_SUM_EN
    .pkt_sum   (pkt_sum),
`endif
    .tx_data   (tx_data),
    .tx_vld    (tx_vld),
    .tx_rdy    (tx_rdy),
    .tx_last   (tx_last),
    .pkt_done  (pkt_done)
  );

  // bench state
  logic [31:0] fifo_q[$];
  logic [8:0]  exp_q[$];     // {last, byte}
  logic [7:0]  got_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int rdy_mode = 0;          // 0: always ready, 1: toggle 1,0,1,0, 2: random
  int stall_pct = 0;         // random fifo_vld suppression
  bit m_busy = 0;
  bit m_done = 0;
  bit last_acc = 0;
  int m_words = 0;
  int m_pend = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int gap_cnt = 0;
  int start_cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
`ifdef ETH_PKT_SERIALIZER_SUM_EN
  longint m_sum = 0;

  function automatic logic [15:0] fold(input longint t);
    longint v;
    v = t;
    while ((v >> 16) != 0) v = (v & 64'hFFFF) + (v >> 16);
    return v[15:0];
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Per-cycle comparison against the model; called at the falling edge.
  task automatic cycle_check();
    bit acc;
    bit pop;
    bit nb;
    bit nd;
    bit rd_exp;
    int sh;
    logic [8:0] e;
    last_acc = 0;
    if (!rst_n) return;
    nb = m_busy;
    nd = 0;
    rd_exp = m_busy && m_words != 0 && (m_pend == 0 || (tx_rdy && m_pend == 1));
    check("busy", 32'(busy), 32'(m_busy));
    check("pkt_done", 32'(pkt_done), 32'(m_done));
    check("tx_vld", 32'(tx_vld), 32'(m_pend != 0));
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(rd_exp));
    if (m_done) begin
      done_cnt++;
`ifdef ETH_PKT_SERIALIZER_SUM_EN
      check("pkt_sum", 32'(pkt_sum), 32'(fold(m_sum)));
`endif
    end
    if (m_busy && m_pend == 0) gap_cnt++;
    if (m_pend != 0) begin
      if (exp_q.size() == 0) begin
        check("exp_queue_empty", 32'(1), 32'(0));
      end else begin
        check("tx_data", 32'(tx_data), 32'(exp_q[0][7:0]));
        check("tx_last", 32'(tx_last), 32'(exp_q[0][8]));
      end
    end else begin
      check("tx_last_idle", 32'(tx_last), 32'(0));
    end
    acc = (m_pend != 0) && tx_rdy && exp_q.size() != 0;
    pop = rd_exp && fifo_vld;
    if (acc) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) first_cyc = cyc;
      last_cyc = cyc;
      got_q.push_back(tx_data);
      m_pend--;
      if (e[8]) begin
        nb = 0;
        nd = 1;
        last_acc = 1;
      end
    end
    if (pop) begin
      m_words--;
      m_pend = 4;
      pop_cnt++;
`ifdef ETH_PKT_SERIALIZER_SUM_EN
      m_sum += longint'(fifo_data[31:16]) + longint'(fifo_data[15:0]);
`endif
      for (int b = 0; b < 4; b++) begin
        sh = (MSB_FIRST != 0) ? 3 - b : b;
        exp_q.push_back({(m_words == 0 && b == 3), fifo_data[sh*8 +: 8]});
      end
    end
    if (!m_busy && pkt_start && pkt_len != '0) begin
      nb = 1;
      m_words = int'(pkt_len);
      m_pend = 0;
      start_cyc = cyc;
`ifdef ETH_PKT_SERIALIZER_SUM_EN
      m_sum = 0;
`endif
    end
    m_busy = nb;
    m_done = nd;
  endtask

  // driver tasks
  task automatic drive_fifo();
    bit stall;
    stall = stall_pct > 0 && $urandom_range(0, 99) < stall_pct;
    fifo_vld  = fifo_q.size() != 0 && !stall;
    fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic drive_rdy();
    case (rdy_mode)
      0: tx_rdy = 1'b1;
      1: tx_rdy = ~tx_rdy;
      default: tx_rdy = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic tick();
    bit popped;
    @(negedge clk);
    cycle_check();
    popped = rst_n && fifo_vld && fifo_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
    drive_rdy();
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  task automatic start_pkt(input int len);
    pkt_start = 1'b1;
    pkt_len   = LEN_W'(len);
    tick();
    pkt_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (done_cnt != d0) return;
    end
    check("pkt_done_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_last_acc(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (last_acc) return;
    end
    check("last_byte_timeout", 32'(0), 32'(1));
  endtask

  task automatic clear_model();
    m_busy = 0; m_done = 0; m_words = 0; m_pend = 0;
    fifo_q.delete();
    exp_q.delete();
    drive_fifo();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_tx_vld"}, 32'(tx_vld), 32'(0));
    check({tag, "_tx_last"}, 32'(tx_last), 32'(0));
    check({tag, "_pkt_done"}, 32'(pkt_done), 32'(0));
    check({tag, "_fifo_rd_en"}, 32'(fifo_rd_en), 32'(0));
    check({tag, "_tx_data"}, 32'(tx_data), 32'(0));
`ifdef ETH_PKT_SERIALIZER_SUM_EN
    check({tag, "_pkt_sum"}, 32'(pkt_sum), 32'(0));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pkt_start = 1'b0;
    #1;
    check_outputs_zero("reset");
    clear_model();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] lit1 [8];

  initial begin
    lit1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    #2;
    do_reset();
    tick();

    // Basic packet, always ready
    got_q.delete(); pop_cnt = 0;
    push_word(32'h11223344); push_word(32'h55667788);
    start_pkt(2);
    wait_done(50);
    check("basic_count", 32'(got_q.size()), 32'(8));
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("basic_byte", 32'(got_q[i]), 32'(lit1[i]));
    check("basic_consecutive", 32'(last_cyc - first_cyc), 32'(7));
    check("basic_latency", 32'(first_cyc - start_cyc), 32'(2));
    check("basic_pops", 32'(pop_cnt), 32'(2));
    tick();

    // Backpressure: tx_rdy toggling
    got_q.delete(); pop_cnt = 0;
    rdy_mode = 1;
    push_word(32'h11223344); push_word(32'h55667788);
    start_pkt(2);
    wait_done(80);
    check("bp_count", 32'(got_q.size()), 32'(8));
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("bp_byte", 32'(got_q[i]), 32'(lit1[i]));
    check("bp_pops", 32'(pop_cnt), 32'(2));
    rdy_mode = 0;
    tick();

    // Underrun: third word arrives late
    got_q.delete(); pop_cnt = 0; gap_cnt = 0;
    push_word(32'hA1A2A3A4); push_word(32'hB1B2B3B4);
    start_pkt(3);
    for (int i = 0; i < 50 && fifo_q.size() != 0; i++) tick();
    repeat (10) tick();
    push_word(32'hC1C2C3C4);
    wait_done(60);
    check("underrun_count", 32'(got_q.size()), 32'(12));
    if (got_q.size() == 12) check("underrun_byte12", 32'(got_q[11]), 32'(8'hC4));
    check("underrun_gap", 32'(gap_cnt >= 6), 32'(1));
    tick();

    // Zero-length start is ignored; word stays in FIFO
    pop_cnt = 0;
    push_word(32'hDEADBEEF);
    start_pkt(0);
    repeat (5) tick();
    check("len0_no_pop", 32'(pop_cnt), 32'(0));
    check("len0_fifo_level", 32'(fifo_q.size()), 32'(1));
    start_pkt(1);
    wait_done(30);
    check("len1_pops", 32'(pop_cnt), 32'(1));

    // pkt_start during SEND is ignored
    pop_cnt = 0;
    push_word(32'h01020304); push_word(32'h05060708); push_word(32'h090A0B0C);
    start_pkt(3);
    repeat (3) tick();
    start_pkt(1);
    wait_done(60);
    check("midsend_pops", 32'(pop_cnt), 32'(3));
    check("midsend_fifo_empty", 32'(fifo_q.size()), 32'(0));
    repeat (3) tick();
    check("midsend_idle_after", 32'(busy), 32'(0));

    // Back-to-back: start in the pkt_done cycle
    pop_cnt = 0;
    push_word(32'h10203040); push_word(32'h50607080); push_word(32'h90A0B0C0);
    start_pkt(2);
    wait_last_acc(40);
    start_pkt(1);
    wait_done(40);
    check("b2b_pops", 32'(pop_cnt), 32'(3));

    // Reset mid-packet, then a clean packet
    push_word(32'hAAAA5555); push_word(32'h12345678); push_word(32'h87654321);
    start_pkt(3);
    repeat (4) tick();
    do_reset();
    tick();
    got_q.delete(); pop_cnt = 0;
    push_word(32'hCAFEF00D); push_word(32'h0BADBEEF);
    start_pkt(2);
    wait_done(50);
    check("post_reset_count", 32'(got_q.size()), 32'(8));
    if (got_q.size() == 8) begin
      check("post_reset_first", 32'(got_q[0]), 32'(8'hCA));
      check("post_reset_last", 32'(got_q[7]), 32'(8'hEF));
    end

`ifdef ETH_PKT_SERIALIZER_SUM_EN
    tick();
    push_word(32'h45000030); push_word(32'h00004000);
    start_pkt(2);
    wait_done(40);
    check("sum_literal", 32'(pkt_sum), 32'(16'h8530));
    tick();
    push_word(32'hFFFF0001);
    start_pkt(1);
    wait_done(30);
    check("sum_carry_fold", 32'(pkt_sum), 32'(16'h0001));
`endif

    // Randomized packets with random backpressure and FIFO stalls
    for (int p = 0; p < 25; p++) begin
      int len;
      len = $urandom_range(1, 6);
      rdy_mode = $urandom_range(0, 2);
      stall_pct = $urandom_range(0, 40);
      got_q.delete(); pop_cnt = 0;
      for (int w = 0; w < len; w++) push_word($urandom());
      repeat ($urandom_range(0, 2)) tick();
      start_pkt(len);
      wait_done(600);
      check("rand_bytes", 32'(got_q.size()), 32'(4 * len));
      check("rand_pops", 32'(pop_cnt), 32'(len));
    end
    rdy_mode = 0;
    stall_pct = 0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
